// File: rtl/memory_arbiter.sv
// Arbitrates datapath instruction fetches and data accesses onto a single RAM port.
// Data requests win ties; a transaction aborts on timeout, RAM error or request drop.
module memory_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        iwait,
   output logic        dwait,
   output logic [31:0] iload,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      INSTR = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   state_t              state, state_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic [ADDR_W-1:0]   lat_addr, addr_next;
   logic [DATA_W-1:0]   lat_data, data_next;
   logic                lat_write, write_next;
   logic                err_next;
   logic                i_done, d_done;
   logic                d_req;
   logic                cnt_expired;
   ramstate_t           rs;

   assign rs          = ramstate_t'(ramstate);
   assign d_req       = dREN | dWEN;
   assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));

   // State and transaction latches; reset drops strobes via state immediately
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_write <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         lat_addr  <= addr_next;
         lat_data  <= data_next;
         lat_write <= write_next;
         err       <= err_next;
      end
   end

   // Next-state, RAM drive and completion decode
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      addr_next  = lat_addr;
      data_next  = lat_data;
      write_next = lat_write;
      err_next   = err;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iload      = '0;
      dload      = '0;
      i_done     = 1'b0;
      d_done     = 1'b0;

      // Conflicting data strobes are flagged; the access proceeds as a write
      if (dREN && dWEN) begin
         err_next = 1'b1;
      end

      case (state)
         IDLE: begin
            if (d_req) begin
               state_next = DATA;
               addr_next  = daddr;
               data_next  = dstore;
               write_next = dWEN;
               cnt_next   = '0;
            end else if (iREN) begin
               state_next = INSTR;
               addr_next  = iaddr;
               data_next  = '0;
               write_next = 1'b0;
               cnt_next   = '0;
            end
         end

         DATA: begin
            ramaddr  = lat_addr;
            ramstore = lat_data;
            ramWEN   = lat_write;
            ramREN   = ~lat_write;
            if (rs == ERROR) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (rs == ACCESS) begin
               d_done     = 1'b1;
               dload      = ramload;
               state_next = IDLE;
            end else if (!d_req) begin
               state_next = IDLE;
            end else if (cnt_expired) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         INSTR: begin
            ramaddr = lat_addr;
            ramREN  = 1'b1;
            if (rs == ERROR) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (rs == ACCESS) begin
               i_done     = 1'b1;
               iload      = ramload;
               state_next = IDLE;
            end else if (!iREN) begin
               state_next = IDLE;
            end else if (cnt_expired) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign iwait = iREN & ~i_done;
   assign dwait = d_req & ~d_done;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: inputs change on the falling edge and
// outputs are sampled 1 ns later, well before the next rising edge.
module tb_memory_arbiter;

   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        iwait;
   logic        dwait;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int busy_cycles;

   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   memory_arbiter #(.TIMEOUT(64)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .iwait    (iwait),
      .dwait    (dwait),
      .iload    (iload),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .err      (err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge (inputs are changed there)
   task automatic next_cycle();
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      iREN     = 1'b0;
      iaddr    = '0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = RS_FREE;
   endtask

   initial begin
      clear_inputs();
      RST  = 1'b1;
      iREN = 1'b1;

      // Reset values; waits mirror the request inputs
      next_cycle(); #1;
      check("rst_iwait", 32'(iwait), 32'd1);
      check("rst_dwait", 32'(dwait), 32'd0);
      check("rst_ramren", 32'(ramREN), 32'd0);
      check("rst_ramaddr", ramaddr, 32'h0);
      check("rst_iload", iload, 32'h0);
      check("rst_err", 32'(err), 32'd0);
      dREN = 1'b1; #1;
      check("rst_dwait_follow", 32'(dwait), 32'd1);

      next_cycle();
      RST = 1'b0;
      clear_inputs();

      // Instruction fetch, ACCESS on the second cycle
      next_cycle();
      iREN = 1'b1; iaddr = 32'h40; #1;
      check("if_idle_iwait", 32'(iwait), 32'd1);
      check("if_idle_ramren", 32'(ramREN), 32'd0);
      next_cycle();
      ramstate = RS_ACCESS; ramload = 32'h8C220004; #1;
      check("if_ramren", 32'(ramREN), 32'd1);
      check("if_ramaddr", ramaddr, 32'h40);
      check("if_iwait_low", 32'(iwait), 32'd0);
      check("if_iload", iload, 32'h8C220004);
      next_cycle();
      clear_inputs(); #1;
      check("if_after_ramren", 32'(ramREN), 32'd0);

      // Simultaneous data write and fetch: data first, then fetch
      next_cycle();
      iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD; #1;
      check("pri_idle_dwait", 32'(dwait), 32'd1);
      check("pri_idle_iwait", 32'(iwait), 32'd1);
      next_cycle();
      ramstate = RS_ACCESS; #1;
      check("pri_ramwen", 32'(ramWEN), 32'd1);
      check("pri_ramren", 32'(ramREN), 32'd0);
      check("pri_ramaddr", ramaddr, 32'h100);
      check("pri_ramstore", ramstore, 32'hDEAD);
      check("pri_dwait_low", 32'(dwait), 32'd0);
      check("pri_iwait_high", 32'(iwait), 32'd1);
      next_cycle();
      dWEN = 1'b0; ramstate = RS_FREE; #1;
      check("pri_gap_ramren", 32'(ramREN), 32'd0);
      check("pri_gap_ramwen", 32'(ramWEN), 32'd0);
      check("pri_gap_iwait", 32'(iwait), 32'd1);
      next_cycle();
      ramstate = RS_ACCESS; ramload = 32'h00001234; #1;
      check("pri_if_ramren", 32'(ramREN), 32'd1);
      check("pri_if_ramaddr", ramaddr, 32'h80);
      check("pri_if_iwait", 32'(iwait), 32'd0);
      check("pri_if_iload", iload, 32'h00001234);
      next_cycle();
      clear_inputs(); #1;
      check("pri_err", 32'(err), 32'd0);

      // Data read completion
      next_cycle();
      dREN = 1'b1; daddr = 32'h600; #1;
      next_cycle();
      ramstate = RS_ACCESS; ramload = 32'hCAFEF00D; #1;
      check("rd_ramren", 32'(ramREN), 32'd1);
      check("rd_ramaddr", ramaddr, 32'h600);
      check("rd_dwait", 32'(dwait), 32'd0);
      check("rd_dload", dload, 32'hCAFEF00D);
      next_cycle();
      clear_inputs();

      // Request dropped while BUSY: quiet return to IDLE
      next_cycle();
      dREN = 1'b1; daddr = 32'h200; ramstate = RS_BUSY; #1;
      next_cycle(); #1;
      check("drop_ramren", 32'(ramREN), 32'd1);
      dREN = 1'b0; #1;
      check("drop_dwait", 32'(dwait), 32'd0);
      next_cycle(); #1;
      check("drop_idle_ramren", 32'(ramREN), 32'd0);
      check("drop_err", 32'(err), 32'd0);

      // Timeout after 64 BUSY cycles in DATA, then retry
      dREN = 1'b1; daddr = 32'h300; ramstate = RS_BUSY; #1;
      busy_cycles = 0;
      for (int i = 0; i < 64; i++) begin
         next_cycle(); #1;
         if (ramREN && dwait) busy_cycles++;
      end
      check("to_len", 32'(busy_cycles), 32'd64);
      check("to_err_before", 32'(err), 32'd0);
      next_cycle(); #1;
      check("to_ramren", 32'(ramREN), 32'd0);
      check("to_err", 32'(err), 32'd1);
      check("to_dwait", 32'(dwait), 32'd1);
      next_cycle(); #1;
      check("to_retry_ramren", 32'(ramREN), 32'd1);
      clear_inputs();
      next_cycle();
      check("to_err_sticky", 32'(err), 32'd1);

      // Reset mid write transaction
      RST = 1'b1;
      next_cycle();
      RST = 1'b0; #1;
      check("rst2_err", 32'(err), 32'd0);
      next_cycle();
      dWEN = 1'b1; daddr = 32'h400; dstore = 32'h5; ramstate = RS_BUSY; #1;
      next_cycle(); #1;
      check("mid_ramwen", 32'(ramWEN), 32'd1);
      #1 RST = 1'b1; #1;
      check("mid_ramwen_drop", 32'(ramWEN), 32'd0);
      check("mid_ramaddr", ramaddr, 32'h0);
      check("mid_dwait", 32'(dwait), 32'd1);
      check("mid_err", 32'(err), 32'd0);
      next_cycle();
      RST = 1'b0;
      clear_inputs(); #1;
      check("mid_after_ramwen", 32'(ramWEN), 32'd0);

      // Conflicting dREN+dWEN performs a write and flags err
      next_cycle();
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; dstore = 32'hBEEF; #1;
      next_cycle();
      ramstate = RS_ACCESS; #1;
      check("both_ramwen", 32'(ramWEN), 32'd1);
      check("both_ramren", 32'(ramREN), 32'd0);
      check("both_ramstore", ramstore, 32'hBEEF);
      check("both_err", 32'(err), 32'd1);
      check("both_dwait", 32'(dwait), 32'd0);
      next_cycle();
      clear_inputs();

      // RAM ERROR during a fetch aborts and sets err
      RST = 1'b1;
      next_cycle();
      RST = 1'b0;
      next_cycle();
      iREN = 1'b1; iaddr = 32'h700; ramstate = RS_ERROR; #1;
      next_cycle(); #1;
      check("rerr_ramren", 32'(ramREN), 32'd1);
      check("rerr_err_before", 32'(err), 32'd0);
      next_cycle(); #1;
      check("rerr_err", 32'(err), 32'd1);
      check("rerr_idle_ramren", 32'(ramREN), 32'd0);
      check("rerr_iwait", 32'(iwait), 32'd1);
      clear_inputs();
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles one RAM transaction may stay outstanding before it is aborted.
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 iREN  in  1  instruction fetch request from the datapath.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 dREN  in  1  data read request (LW/LUI path).
REQ-007 dWEN  in  1  data write request (SW path).
REQ-008 daddr  in  32  data word address.
REQ-009 dstore  in  32  data to write.
REQ-010 iwait  out  1  high while the instruction request is not yet served.
REQ-011 dwait  out  1  high while the data request is not yet served.
REQ-012 iload  out  32  fetched instruction; valid only in the cycle iwait is low with iREN high.
REQ-013 dload  out  32  read data; valid only in the cycle dwait is low with dREN high.
REQ-014 ramREN, ramWEN  out  1 each  RAM read and write strobes.
REQ-015 ramaddr  out  32  RAM address.
REQ-016 ramstore  out  32  RAM write data.
REQ-017 ramload  in  32  RAM read data.
REQ-018 ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-019 err  out  1  sticky fault flag (timeout, RAM ERROR, or dREN and dWEN high together).

Function
REQ-020 FSM states: IDLE, DATA, INSTR.
REQ-021 IDLE: if dREN or dWEN is high, go to DATA and latch daddr, dstore, and op (write when dWEN is high); else if iREN is high, go to INSTR and latch iaddr; else stay.
REQ-022 Data requests have priority over instruction requests that arrive in the same cycle.
REQ-023 DATA: ramaddr is the latched daddr, ramstore is the latched dstore, ramWEN is high for a write, ramREN is high for a read; ramREN and ramWEN are never high together.
REQ-024 INSTR: ramaddr is the latched iaddr and ramREN is high.
REQ-025 Completion: ramstate is ACCESS while in DATA or INSTR. In that same cycle the matching wait goes low for exactly one cycle, dload or iload equals ramload, and the next state is IDLE.
REQ-026 Minimum latency from request to wait-low is 2 cycles: one cycle for IDLE, plus the RAM access cycle.
REQ-027 Outside DATA and INSTR, and in IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-028 iwait = iREN and not (INSTR completing). dwait = (dREN or dWEN) and not (DATA completing).
REQ-029 Abort: if the active request drops before ACCESS, the next state is IDLE with no wait-low pulse and err unchanged.
REQ-030 An 8-bit cycle counter clears on entry to DATA or INSTR and increments each cycle in those states while ramstate is not ACCESS.
REQ-031 When the counter reaches TIMEOUT-1 with no ACCESS: go to IDLE, set err, and keep wait high so the requester retries.
REQ-032 ramstate ERROR in DATA or INSTR sets err and aborts the transaction to IDLE.
REQ-033 dREN and dWEN high together set err; the access is performed as a write.
REQ-034 err stays high until reset.
REQ-035 After a data completion, the FSM returns to IDLE before any pending instruction fetch is serviced.

Reset
REQ-036 With RST high: state=IDLE, counter=0, latched address/data/op=0, err=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
REQ-037 While RST is high, iwait and dwait follow REQ-028 with no completion, so they equal the request inputs.
REQ-038 Reset asserted mid-transaction drops the RAM strobes immediately (asynchronously); no completion is signalled.

Verification
REQ-039 iREN=1, iaddr=0x40, ramstate ACCESS on 2nd cycle with ramload=0x8C220004 -> ramREN=1 with ramaddr=0x40, iwait low for 1 cycle with iload=0x8C220004.
REQ-040 iREN=1 and dWEN=1 in the same cycle, daddr=0x100, dstore=0xDEAD -> data write is served first (ramWEN=1, ramstore=0xDEAD, dwait pulse), then the instruction fetch at iaddr completes.
REQ-041 dREN=1, ramstate held BUSY for 70 cycles -> abort at TIMEOUT, err=1, dwait stays 1, ramREN=0 the cycle after.
REQ-042 dREN=1 then dREN=0 on 2nd cycle while ramstate BUSY -> FSM returns to IDLE, no dwait pulse, err=0.
REQ-043 RST pulsed while in DATA with ramWEN=1 -> ramWEN=0 immediately, state IDLE, err=0.
REQ-044 dREN=1 and dWEN=1 together -> err=1 and a RAM write is issued.
